// File: rtl/shot_controller.sv
// shot_controller: arbitrates player shots onto the shared game-board memory.
// Enforces turn order, rejects illegal coordinates and performs the
// read-evaluate-write on the opponent's board bank. It also tracks the hit
// count of each player, declares the winner and reports every shot result.
// Every output is driven straight from a register.

module shot_controller #(
  parameter int BOARD_N    = 10,
  parameter int SHIP_CELLS = 20,
  parameter int HW         = $clog2(SHIP_CELLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          first_turn,
  input  logic [1:0]    req,
  input  logic [3:0]    x0,
  input  logic [3:0]    y0,
  input  logic [3:0]    x1,
  input  logic [3:0]    y1,
  output logic [1:0]    ack,
  output logic          brd_bank,
  output logic [3:0]    brd_x,
  output logic [3:0]    brd_y,
  output logic          brd_re,
  input  logic [1:0]    brd_rd_data,
  output logic          brd_we,
  output logic [1:0]    brd_wr_data,
  output logic          res_valid,
  output logic          res_src,
  output logic [2:0]    res_code,
  output logic          turn,
  output logic [HW-1:0] hits0,
  output logic [HW-1:0] hits1,
  output logic          game_over,
  output logic          winner
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  // Result codes
  localparam logic [2:0] RES_MISS      = 3'd0;
  localparam logic [2:0] RES_HIT       = 3'd1;
  localparam logic [2:0] RES_REPEAT    = 3'd2;
  localparam logic [2:0] RES_NOT_TURN  = 3'd3;
  localparam logic [2:0] RES_BAD_COORD = 3'd4;

  // Cell values
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  // One extra bit lets the limit reach 16 without wrapping.
  localparam logic [4:0]    BOARD_LIM = 5'(BOARD_N);
  localparam logic [HW-1:0] SHIP_MAX  = HW'(SHIP_CELLS);

  // Value written back to a cell that has just been shot.
  function automatic logic [1:0] mark_cell(input logic was_ship);
    if (was_ship) begin
      mark_cell = CELL_HIT;
    end else begin
      mark_cell = CELL_MISS;
    end
  endfunction

  // Saturating increment of a hit counter.
  function automatic logic [HW-1:0] bump_hits(input logic [HW-1:0] cnt);
    if (cnt < SHIP_MAX) begin
      bump_hits = cnt + {{(HW-1){1'b0}}, 1'b1};
    end else begin
      bump_hits = cnt;
    end
  endfunction

  logic [2:0]    state_q, state_d;
  logic          src_q, src_d;
  logic          bank_q, bank_d;
  logic [3:0]    bx_q, bx_d;
  logic [3:0]    by_q, by_d;
  logic [1:0]    ack_q, ack_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic [1:0]    wr_data_q, wr_data_d;
  logic          res_valid_q, res_valid_d;
  logic          res_src_q, res_src_d;
  logic [2:0]    res_code_q, res_code_d;
  logic [2:0]    pend_code_q, pend_code_d;
  logic          turn_q, turn_d;
  logic          turn_load_q, turn_load_d;
  logic [HW-1:0] hits0_q, hits0_d;
  logic [HW-1:0] hits1_q, hits1_d;
  logic          over_q, over_d;
  logic          winner_q, winner_d;

  logic          sel_valid_s;
  logic          sel_src_s;
  logic [3:0]    sel_x_s;
  logic [3:0]    sel_y_s;
  logic          sel_bad_s;
  logic [HW-1:0] src_hits_s;

  // Request selection: turn holder first, then the out-of-turn player.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_src_s   = turn_q;
    if (req[turn_q]) begin
      sel_valid_s = 1'b1;
      sel_src_s   = turn_q;
    end else if (req[~turn_q]) begin
      sel_valid_s = 1'b1;
      sel_src_s   = ~turn_q;
    end else begin
      sel_valid_s = 1'b0;
    end
    if (sel_src_s) begin
      sel_x_s = x1;
      sel_y_s = y1;
    end else begin
      sel_x_s = x0;
      sel_y_s = y0;
    end
    sel_bad_s = ({1'b0, sel_x_s} >= BOARD_LIM) || ({1'b0, sel_y_s} >= BOARD_LIM);
    if (src_q) begin
      src_hits_s = hits1_q;
    end else begin
      src_hits_s = hits0_q;
    end
  end

  // Next-state logic for the shot sequencer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    bank_d      = bank_q;
    bx_d        = bx_q;
    by_d        = by_q;
    ack_d       = 2'b00;
    re_d        = 1'b0;
    we_d        = 1'b0;
    wr_data_d   = wr_data_q;
    res_valid_d = 1'b0;
    res_src_d   = res_src_q;
    res_code_d  = res_code_q;
    pend_code_d = pend_code_q;
    turn_d      = turn_q;
    turn_load_d = 1'b0;
    hits0_d     = hits0_q;
    hits1_d     = hits1_q;
    over_d      = over_q;
    winner_d    = winner_q;

    if (turn_load_q) begin
      // First cycle after reset release: adopt the configured starting player.
      turn_d = first_turn;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (new_game) begin
            hits0_d  = {HW{1'b0}};
            hits1_d  = {HW{1'b0}};
            over_d   = 1'b0;
            winner_d = 1'b0;
            turn_d   = first_turn;
          end else if (sel_valid_s) begin
            ack_d     = sel_src_s ? 2'b10 : 2'b01;
            res_src_d = sel_src_s;
            if (sel_src_s != turn_q) begin
              res_valid_d = 1'b1;
              res_code_d  = RES_NOT_TURN;
            end else if (sel_bad_s) begin
              res_valid_d = 1'b1;
              res_code_d  = RES_BAD_COORD;
            end else begin
              src_d   = sel_src_s;
              bank_d  = ~sel_src_s;
              bx_d    = sel_x_s;
              by_d    = sel_y_s;
              re_d    = 1'b1;
              state_d = S_READ;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_READ: begin
          state_d = S_EVAL;
        end
        S_EVAL: begin
          case (brd_rd_data)
            CELL_EMPTY: begin
              we_d        = 1'b1;
              wr_data_d   = mark_cell(1'b0);
              pend_code_d = RES_MISS;
              state_d     = S_WRITE;
            end
            CELL_SHIP: begin
              we_d        = 1'b1;
              wr_data_d   = mark_cell(1'b1);
              pend_code_d = RES_HIT;
              state_d     = S_WRITE;
              if (src_q) begin
                hits1_d = bump_hits(hits1_q);
              end else begin
                hits0_d = bump_hits(hits0_q);
              end
            end
            default: begin
              // Cell already shot: report it, leave the board untouched.
              res_valid_d = 1'b1;
              res_src_d   = src_q;
              res_code_d  = RES_REPEAT;
              state_d     = S_DONE;
            end
          endcase
        end
        S_WRITE: begin
          res_valid_d = 1'b1;
          res_src_d   = src_q;
          res_code_d  = pend_code_q;
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (src_hits_s == SHIP_MAX) begin
            over_d   = 1'b1;
            winner_d = src_q;
            state_d  = S_OVER;
          end else begin
            state_d = S_IDLE;
            // Only a miss passes the turn; hits and repeats keep it.
            if (res_code_q == RES_MISS) begin
              turn_d = ~turn_q;
            end else begin
              turn_d = turn_q;
            end
          end
        end
        S_OVER: begin
          if (new_game) begin
            hits0_d  = {HW{1'b0}};
            hits1_d  = {HW{1'b0}};
            over_d   = 1'b0;
            winner_d = 1'b0;
            turn_d   = first_turn;
            state_d  = S_IDLE;
          end else if (sel_valid_s) begin
            ack_d       = sel_src_s ? 2'b10 : 2'b01;
            res_valid_d = 1'b1;
            res_src_d   = sel_src_s;
            res_code_d  = RES_NOT_TURN;
          end else begin
            state_d = S_OVER;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any shot in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_q       <= 1'b0;
      bank_q      <= 1'b0;
      bx_q        <= 4'd0;
      by_q        <= 4'd0;
      ack_q       <= 2'b00;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      wr_data_q   <= 2'b00;
      res_valid_q <= 1'b0;
      res_src_q   <= 1'b0;
      res_code_q  <= 3'd0;
      pend_code_q <= 3'd0;
      turn_q      <= 1'b0;
      turn_load_q <= 1'b1;
      hits0_q     <= {HW{1'b0}};
      hits1_q     <= {HW{1'b0}};
      over_q      <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      bank_q      <= bank_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      ack_q       <= ack_d;
      re_q        <= re_d;
      we_q        <= we_d;
      wr_data_q   <= wr_data_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      res_code_q  <= res_code_d;
      pend_code_q <= pend_code_d;
      turn_q      <= turn_d;
      turn_load_q <= turn_load_d;
      hits0_q     <= hits0_d;
      hits1_q     <= hits1_d;
      over_q      <= over_d;
      winner_q    <= winner_d;
    end
  end

  assign ack         = ack_q;
  assign brd_bank    = bank_q;
  assign brd_x       = bx_q;
  assign brd_y       = by_q;
  assign brd_re      = re_q;
  assign brd_we      = we_q;
  assign brd_wr_data = wr_data_q;
  assign res_valid   = res_valid_q;
  assign res_src     = res_src_q;
  assign res_code    = res_code_q;
  assign turn        = turn_q;
  assign hits0       = hits0_q;
  assign hits1       = hits1_q;
  assign game_over   = over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller with a small two-bank board memory.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_shot_controller;

  localparam int HW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          new_game;
  logic          first_turn;
  logic [1:0]    req;
  logic [3:0]    x0, y0, x1, y1;
  logic [1:0]    ack;
  logic          brd_bank;
  logic [3:0]    brd_x, brd_y;
  logic          brd_re;
  logic [1:0]    brd_rd_data;
  logic          brd_we;
  logic [1:0]    brd_wr_data;
  logic          res_valid;
  logic          res_src;
  logic [2:0]    res_code;
  logic          turn;
  logic [HW-1:0] hits0, hits1;
  logic          game_over;
  logic          winner;

  logic          mem_init;
  logic [1:0]    mem [0:1][0:15][0:15];
  int            we_cnt = 0;
  int            re_cnt = 0;
  int            vectors = 0;
  int            fails = 0;
  int            snap;

  shot_controller #(.BOARD_N(10), .SHIP_CELLS(2)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .first_turn(first_turn),
    .req(req), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .ack(ack),
    .brd_bank(brd_bank), .brd_x(brd_x), .brd_y(brd_y), .brd_re(brd_re),
    .brd_rd_data(brd_rd_data), .brd_we(brd_we), .brd_wr_data(brd_wr_data),
    .res_valid(res_valid), .res_src(res_src), .res_code(res_code),
    .turn(turn), .hits0(hits0), .hits1(hits1), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  // Board memory: synchronous read (data one cycle after re), synchronous write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++)
          for (int j = 0; j < 16; j++)
            mem[b][i][j] <= 2'b00;
      mem[0][9][9] <= 2'b01;
      mem[1][0][0] <= 2'b01;
      mem[1][1][1] <= 2'b01;
      brd_rd_data  <= 2'b00;
    end else begin
      if (brd_re) brd_rd_data <= mem[brd_bank][brd_x][brd_y];
      if (brd_we) mem[brd_bank][brd_x][brd_y] <= brd_wr_data;
    end
  end

  // Strobe counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (brd_we) we_cnt <= we_cnt + 1;
    if (brd_re) re_cnt <= re_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1; new_game = 1'b0; first_turn = 1'b0;
    req = 2'b00; x0 = 4'd0; y0 = 4'd0; x1 = 4'd0; y1 = 4'd0;
    repeat (3) step();
    mem_init = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_re", 32'(brd_re), 32'd0);
    check("rst_we", 32'(brd_we), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_hits0", 32'(hits0), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_turn", 32'(turn), 32'd0);
    rst = 1'b0;
    step();
    check("init_turn", 32'(turn), 32'd0);

    // Miss: player 0 at (2,3) on bank 1
    req = 2'b01; x0 = 4'd2; y0 = 4'd3;
    step();
    check("miss_ack", 32'(ack), 32'd1);
    check("miss_re", 32'(brd_re), 32'd1);
    check("miss_bank", 32'(brd_bank), 32'd1);
    check("miss_addr", 32'({brd_x, brd_y}), 32'h23);
    req = 2'b00;
    step();
    check("miss_re_off", 32'(brd_re), 32'd0);
    step();
    check("miss_we", 32'(brd_we), 32'd1);
    check("miss_wdata", 32'(brd_wr_data), 32'd2);
    check("miss_no_res_t3", 32'(res_valid), 32'd0);
    step();
    check("miss_res_valid", 32'(res_valid), 32'd1);
    check("miss_code", 32'(res_code), 32'd0);
    check("miss_src", 32'(res_src), 32'd0);
    check("miss_we_off", 32'(brd_we), 32'd0);
    check("miss_mem", 32'(mem[1][2][3]), 32'd2);
    step();
    check("miss_turn", 32'(turn), 32'd1);

    // Hit: player 1 at (9,9) on bank 0
    req = 2'b10; x1 = 4'd9; y1 = 4'd9;
    step();
    check("hit_ack", 32'(ack), 32'd2);
    check("hit_bank", 32'(brd_bank), 32'd0);
    req = 2'b00;
    step();
    step();
    check("hit_we", 32'(brd_we), 32'd1);
    check("hit_wdata", 32'(brd_wr_data), 32'd3);
    step();
    check("hit_code", 32'({res_valid, res_code}), 32'h9);
    check("hit_src", 32'(res_src), 32'd1);
    check("hit_hits1", 32'(hits1), 32'd1);
    step();
    check("hit_turn", 32'(turn), 32'd1);

    // Repeat: player 1 fires (9,9) again
    snap = we_cnt;
    req = 2'b10;
    step();
    check("rep_ack", 32'(ack), 32'd2);
    req = 2'b00;
    step();
    step();
    check("rep_code", 32'({res_valid, res_code}), 32'ha);
    check("rep_no_we", 32'(brd_we), 32'd0);
    step();
    check("rep_valid_off", 32'(res_valid), 32'd0);
    check("rep_we_cnt", 32'(we_cnt), 32'(snap));
    check("rep_hits1", 32'(hits1), 32'd1);
    check("rep_turn", 32'(turn), 32'd1);

    // Player 1 misses at (5,5): turn passes to player 0
    req = 2'b10; x1 = 4'd5; y1 = 4'd5;
    step();
    req = 2'b00;
    repeat (3) step();
    check("p1miss_code", 32'({res_valid, res_code, res_src}), 32'h11);
    step();
    check("p1miss_turn", 32'(turn), 32'd0);

    // Contention: both request, player 0 hits (0,0), player 1 then gets NOT_TURN
    req = 2'b11; x0 = 4'd0; y0 = 4'd0;
    step();
    check("cont_ack0", 32'(ack), 32'd1);
    req = 2'b10;
    repeat (3) step();
    check("cont_hit", 32'({res_valid, res_code, res_src}), 32'h12);
    check("cont_hits0", 32'(hits0), 32'd1);
    check("cont_no_ack", 32'(ack), 32'd0);
    step();
    step();
    check("cont_ack1", 32'(ack), 32'd2);
    check("cont_not_turn", 32'({res_valid, res_code, res_src}), 32'h17);

    // Bad coordinate: x0=10
    snap = re_cnt;
    req = 2'b01; x0 = 4'd10; y0 = 4'd0;
    step();
    check("bad_ack", 32'(ack), 32'd1);
    check("bad_code", 32'({res_valid, res_code, res_src}), 32'h18);
    check("bad_no_re", 32'(brd_re), 32'd0);
    req = 2'b00;
    step();
    check("bad_re_cnt", 32'(re_cnt), 32'(snap));

    // Game over: player 0 hits (1,1), reaching SHIP_CELLS=2
    req = 2'b01; x0 = 4'd1; y0 = 4'd1;
    step();
    req = 2'b00;
    step();
    step();
    check("go_wdata", 32'({brd_we, brd_wr_data}), 32'h7);
    check("go_hits0", 32'(hits0), 32'd2);
    step();
    check("go_hit", 32'({res_valid, res_code, res_src}), 32'h12);
    step();
    check("go_flag", 32'({game_over, winner}), 32'h2);

    // In OVER: request acked but reported NOT_TURN, no board access
    snap = re_cnt;
    req = 2'b10;
    step();
    check("over_ack", 32'(ack), 32'd2);
    check("over_code", 32'({res_valid, res_code, res_src}), 32'h17);
    req = 2'b00;
    step();
    check("over_no_re", 32'(re_cnt), 32'(snap));

    // new_game with first_turn=1
    first_turn = 1'b1; new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("ng_hits", 32'({hits0, hits1}), 32'd0);
    check("ng_over", 32'(game_over), 32'd0);
    check("ng_turn", 32'(turn), 32'd1);

    // Reset in WRITE: player 1 at (3,4), abort before the write lands
    req = 2'b10; x1 = 4'd3; y1 = 4'd4;
    step();
    req = 2'b00;
    step();
    step();
    check("rw_we_before", 32'(brd_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rw_we_killed", 32'(brd_we), 32'd0);
    check("rw_outputs", 32'({ack, res_valid, turn, brd_x}), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("rw_mem_kept", 32'(mem[0][3][4]), 32'd0);
    check("rw_turn_load", 32'(turn), 32'd1);

    // Same shot runs normally after reset
    req = 2'b10;
    step();
    check("rw2_ack", 32'(ack), 32'd2);
    req = 2'b00;
    step();
    step();
    check("rw2_we", 32'({brd_we, brd_wr_data}), 32'h6);
    step();
    check("rw2_res", 32'({res_valid, res_code, res_src}), 32'h11);
    check("rw2_mem", 32'(mem[0][3][4]), 32'd2);
    step();
    check("rw2_turn", 32'(turn), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Sequences all shot traffic onto the shared 10x10 game-board memory. Cells are 2-bit: 00 empty, 01 ship, 10 miss, 11 hit.
- Two requesters can shoot: player 0 (local, mouse/keyboard) and player 1 (remote, UART link).
- The block enforces turns, validates coordinates and performs the read-evaluate-write on the target board bank.
- It keeps per-player hit counts, declares game over and reports each shot result to the display and link layers.

Parameters:
- BOARD_N, 10, board edge length; legal coordinates are 0..BOARD_N-1.
- SHIP_CELLS, 20, total ship cells per board; this hit count wins the game.
- HW, $clog2(SHIP_CELLS+1), width of the hit counters (derived; do not override).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- new_game  input  1  one-cycle pulse that restarts the game; honoured only in IDLE or OVER.
- first_turn  input  1  player whose turn it is after new_game or reset-release: 0 or 1.
- req  input  2  per-player shot request, level; held until the matching ack.
- x0, y0  input  4 each  player 0 shot coordinates, valid while req[0].
- x1, y1  input  4 each  player 1 shot coordinates, valid while req[1].
- ack  output  2  one-cycle pulse; request consumed.
- brd_bank  output  1  board bank to access: the opponent of the shooter, i.e. NOT shooter.
- brd_x, brd_y  output  4 each  board address.
- brd_re  output  1  read strobe. Read data is valid one cycle later.
- brd_rd_data  input  2  cell value.
- brd_we  output  1  write strobe.
- brd_wr_data  output  2  cell value to write.
- res_valid  output  1  one-cycle pulse; result fields are valid.
- res_src  output  1  shooter of the reported result.
- res_code  output  3  0 MISS, 1 HIT, 2 REPEAT, 3 NOT_TURN, 4 BAD_COORD.
- turn  output  1  player currently allowed to shoot.
- hits0, hits1  output  HW each  ship cells hit by player 0 and player 1.
- game_over  output  1  level; set when a player reaches SHIP_CELLS hits.
- winner  output  1  valid while game_over.

Behaviour:
- Reset values: all strobes, ack, res_* and board outputs 0; hits 0; game_over 0; winner 0; state IDLE.
  - turn takes first_turn, registered on the first clock after reset release.
- FSM states: IDLE, READ, EVAL, WRITE, DONE, OVER. All outputs are registered.
- IDLE (cycle t), request selection:
  - If req[turn]=1, the turn holder is selected.
  - Otherwise, if req[~turn]=1, the out-of-turn player is selected.
- IDLE, out-of-turn player selected: at t+1 ack and res_valid pulse with code NOT_TURN; state stays IDLE.
- IDLE, turn holder selected with x or y >= BOARD_N: at t+1 ack and res_valid pulse with code BAD_COORD; no board access; state stays IDLE.
- IDLE, turn holder selected with legal coordinates:
  - Latch x, y and src.
  - At t+1: ack pulses, brd_re=1, brd_x/brd_y/brd_bank are driven; state moves to READ.
- READ → EVAL: brd_rd_data is sampled in EVAL at t+2.
- EVAL decision on the sampled cell:
  - 00: write 10 (miss); code MISS; turn toggles after DONE.
  - 01: write 11 (hit); code HIT; hits[src]+1 saturating at SHIP_CELLS; turn unchanged (a hit shoots again).
  - 10 or 11: no write; code REPEAT; turn unchanged; go directly to DONE.
- WRITE (t+3): brd_we=1 for exactly one cycle; address and bank held from READ.
- DONE:
  - Result timing: res_valid pulses at t+4 for MISS/HIT, at t+3 for REPEAT.
  - If hits[src]==SHIP_CELLS: go to OVER, set game_over=1, winner=src. Otherwise go to IDLE.
- OVER:
  - Requests are still acked, but every result is reported with code NOT_TURN.
  - There is no board access.
  - new_game clears hits, game_over and winner, loads turn=first_turn, and returns to IDLE.
- new_game pulsed in READ/EVAL/WRITE/DONE is ignored; the current shot completes.
- Only one shot is in flight at a time. Requests are not sampled outside IDLE/OVER.
- Board address outputs hold their last value when idle. brd_re and brd_we are never high together.
- rst asserted mid-shot aborts immediately: no write strobe is issued after reset assertion.

Test Plan:
- Miss: reset with first_turn=0; board0 bank1 (2,3)=00; req[0] with (2,3).
  - Required: ack[0] at t+1; brd_we at t+3 with data 10; res_valid at t+4 with MISS, src 0; turn becomes 1.
- Hit: turn=1; bank0 (9,9)=01; req[1] with (9,9).
  - Required: write 11; HIT; hits1=1; turn stays 1.
- Repeat: re-fire (9,9).
  - Required: REPEAT at t+3; no brd_we; hits1 unchanged.
- Contention and bad coordinates:
  - With turn=0, req=2'b11: player 0 is served first; player 1 is then answered NOT_TURN (or served if the turn passed).
  - x0=10 gives BAD_COORD with no brd_re.
- Game over: SHIP_CELLS=2; player 0 hits two ship cells.
  - Required: game_over=1, winner=0. A further request gives NOT_TURN. new_game with first_turn=1 clears hits and sets turn=1.
- Reset mid-shot: assert rst in the WRITE state.
  - Required: brd_we=0 immediately; all outputs at reset values; the next shot runs normally.
